// File: rtl/mult_block_host.sv
// Host-side initiator for the block multiplier: streams 2^LOGDEPTH generated operand pairs,
// reads the stored block back and checks every product, accumulating checksum and error count.
module mult_block_host #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         seed_a,
    input  logic [15:0]         seed_b,
    input  logic [15:0]         step_a,
    input  logic [15:0]         step_b,
    output logic                EN_mult,
    output logic [15:0]         mult_input0,
    output logic [15:0]         mult_input1,
    input  logic                RDY_mult,
    output logic                EN_blockRead,
    input  logic                VALID_memVal,
    input  logic [WIDTH-1:0]    memVal_data,
    output logic                busy,
    output logic                done,
    output logic [LOGDEPTH:0]   rx_count,
    output logic [LOGDEPTH:0]   err_count,
    output logic [WIDTH-1:0]    checksum,
    output logic                timeout
);

    // state      | meaning
    // S_IDLE     | waiting for start; results of last block held
    // S_ISSUE    | presenting operand pairs to the multiplier
    // S_WAIT_FULL| all pairs sent, waiting for RDY_mult to fall
    // S_REQ      | EN_blockRead high until the first returned word
    // S_COLLECT  | checking returned words in index order
    // S_DONE     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_FULL, S_REQ, S_COLLECT, S_DONE
    } state_t;

    localparam int DEPTH = 1 << LOGDEPTH;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LOGDEPTH:0] LAST    = (LOGDEPTH + 1)'(DEPTH - 1);
    localparam logic [LOGDEPTH:0] CNT_ONE = (LOGDEPTH + 1)'(1);
    localparam logic [TW-1:0]     TMR_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0]     TMR_ONE = TW'(1);

    state_t state_q, state_d;

    logic [LOGDEPTH:0] iss_idx;
    logic [15:0]       op_a, op_b, stp_a, stp_b, exp_a, exp_b;
    logic [TW-1:0]     timer;
    logic [31:0]       exp_prod;
    logic              mismatch;

    logic start_blk, accept, proc_word, tmr_load, tmr_dec, set_timeout;

    assign exp_prod = 32'(exp_a) * 32'(exp_b);
    assign mismatch = (memVal_data != WIDTH'(exp_prod));

    assign EN_mult      = (state_q == S_ISSUE);
    assign EN_blockRead = (state_q == S_REQ);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign mult_input0  = op_a;
    assign mult_input1  = op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_blk   = 1'b0;
        accept      = 1'b0;
        proc_word   = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_blk = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (RDY_mult) begin
                    accept = 1'b1;
                    if (iss_idx == LAST) begin
                        tmr_load = 1'b1;
                        state_d  = S_WAIT_FULL;
                    end
                end
            end
            S_WAIT_FULL: begin
                if (!RDY_mult) begin
                    tmr_load = 1'b1;
                    state_d  = S_REQ;
                end else if (timer == '0) begin
                    set_timeout = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_REQ: begin
                if (VALID_memVal) begin
                    proc_word = 1'b1;
                    state_d   = (DEPTH == 1) ? S_DONE : S_COLLECT;
                end else if (timer == '0) begin
                    set_timeout = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_COLLECT: begin
                if (!VALID_memVal) begin
                    state_d = S_DONE;
                end else begin
                    proc_word = 1'b1;
                    if (rx_count == LAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand generation and the expected-product sequence advance independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_idx   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            stp_a     <= '0;
            stp_b     <= '0;
            exp_a     <= '0;
            exp_b     <= '0;
            timer     <= '0;
            rx_count  <= '0;
            err_count <= '0;
            checksum  <= '0;
            timeout   <= 1'b0;
        end else begin
            if (start_blk) begin
                iss_idx   <= '0;
                op_a      <= seed_a;
                op_b      <= seed_b;
                stp_a     <= step_a;
                stp_b     <= step_b;
                exp_a     <= seed_a;
                exp_b     <= seed_b;
                rx_count  <= '0;
                err_count <= '0;
                checksum  <= '0;
                timeout   <= 1'b0;
            end
            if (accept) begin
                iss_idx <= iss_idx + CNT_ONE;
                op_a    <= op_a + stp_a;
                op_b    <= op_b + stp_b;
            end
            if (tmr_load)      timer <= TMR_MAX;
            else if (tmr_dec)  timer <= timer - TMR_ONE;
            if (set_timeout)   timeout <= 1'b1;
            if (proc_word) begin
                checksum <= checksum + memVal_data;
                rx_count <= rx_count + CNT_ONE;
                if (mismatch) err_count <= err_count + CNT_ONE;
                exp_a <= exp_a + stp_a;
                exp_b <= exp_b + stp_b;
            end
        end
    end

endmodule

// File: tb/tb_mult_block_host.sv
// Directed bench for mult_block_host with a behavioural block multiplier driven per cycle.
module tb_mult_block_host;

    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 1 << LOGDEPTH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [15:0]         seed_a = '0, seed_b = '0, step_a = '0, step_b = '0;
    logic                EN_mult;
    logic [15:0]         mult_input0, mult_input1;
    logic                RDY_mult = 1'b0;
    logic                EN_blockRead;
    logic                VALID_memVal = 1'b0;
    logic [WIDTH-1:0]    memVal_data = '0;
    logic                busy, done, timeout;
    logic [LOGDEPTH:0]   rx_count, err_count;
    logic [WIDTH-1:0]    checksum;

    int pass_cnt = 0;
    int total_cnt = 0;

    int          r_acc, r_issue_cycles, r_done_pulses, r_wait_cycles, r_pair_err;
    bit          r_br_seen, r_br_late, r_first_en, r_en_drop, r_bound_hit;
    logic [15:0] r_held_a, r_held_b;

    mult_block_host #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .seed_a(seed_a), .seed_b(seed_b), .step_a(step_a), .step_b(step_b),
        .EN_mult(EN_mult), .mult_input0(mult_input0), .mult_input1(mult_input1),
        .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .busy(busy), .done(done), .rx_count(rx_count), .err_count(err_count),
        .checksum(checksum), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Runs one block; the multiplier model stores products of the pairs it accepts.
    task automatic run_block(input logic [15:0] sa, sta, sb, stb,
                             input int stall_at, stall_len, corrupt_idx, n_words,
                             input bit never_full);
        logic [WIDTH-1:0] prod [DEPTH];
        logic [15:0] ea, eb;
        int stall_cnt = 0, sent = 0, cyc = 0, post = 0;
        bit full = 0, sending = 0, finished = 0, first_post = 1;
        r_acc = 0; r_issue_cycles = 0; r_done_pulses = 0; r_wait_cycles = 0; r_pair_err = 0;
        r_br_seen = 0; r_br_late = 0; r_en_drop = 0; r_held_a = '0; r_held_b = '0;
        @(negedge clk);
        seed_a = sa; step_a = sta; seed_b = sb; step_b = stb;
        start = 1'b1; RDY_mult = 1'b0; VALID_memVal = 1'b0;
        @(negedge clk);
        start = 1'b0;
        r_first_en = EN_mult;
        while (post < 4 && cyc < 3000) begin
            if (done) begin r_done_pulses++; finished = 1; end
            if (EN_blockRead) r_br_seen = 1;
            if (sent > 0 && EN_blockRead) r_br_late = 1;
            if (!full) begin
                ea = sa + 16'(r_acc) * sta;
                eb = sb + 16'(r_acc) * stb;
                if (EN_mult) r_issue_cycles++;
                if (EN_mult && (mult_input0 !== ea || mult_input1 !== eb)) r_pair_err++;
                if (r_acc == stall_at && stall_cnt < stall_len) begin
                    RDY_mult = 1'b0;
                    stall_cnt++;
                    r_held_a = mult_input0; r_held_b = mult_input1;
                end else begin
                    RDY_mult = 1'b1;
                    if (EN_mult) begin
                        prod[r_acc] = WIDTH'(32'(mult_input0) * 32'(mult_input1));
                        r_acc++;
                        if (r_acc == DEPTH) full = 1;
                    end
                end
            end else begin
                if (first_post) begin r_en_drop = (EN_mult === 1'b0); first_post = 0; end
                if (!finished) r_wait_cycles++;
                RDY_mult = never_full;
                if (EN_blockRead) sending = 1;
                if (sending && sent < n_words) begin
                    VALID_memVal = 1'b1;
                    memVal_data = prod[sent];
                    if (sent == corrupt_idx) memVal_data[0] = ~memVal_data[0];
                    sent++;
                end else begin
                    VALID_memVal = 1'b0;
                end
            end
            if (finished) post++;
            @(negedge clk);
            cyc++;
        end
        r_bound_hit = (post < 4);
        VALID_memVal = 1'b0;
        RDY_mult = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++; if ({EN_mult, EN_blockRead, busy, done, timeout} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {EN_mult, EN_blockRead, busy, done, timeout}); else pass_cnt++;
        total_cnt++; if ({rx_count, err_count, checksum} !== '0) $display("FAIL reset_counts rx=%0d err=%0d sum=%0d want 0", rx_count, err_count, checksum); else pass_cnt++;
        total_cnt++; if ({mult_input0, mult_input1} !== 32'h0) $display("FAIL reset_operands got %h want 0", {mult_input0, mult_input1}); else pass_cnt++;
    endtask

    task automatic test_nominal();
        run_block(16'd1, 16'd1, 16'd2, 16'd0, -1, 0, -1, DEPTH, 0);
        total_cnt++; if (r_bound_hit) $display("FAIL nom_bound cycle budget expired got 1 want 0"); else pass_cnt++;
        total_cnt++; if (r_first_en !== 1'b1) $display("FAIL nom_first_en got %b want 1", r_first_en); else pass_cnt++;
        total_cnt++; if (r_acc != 64 || r_issue_cycles != 64) $display("FAIL nom_issue acc=%0d cycles=%0d want 64/64", r_acc, r_issue_cycles); else pass_cnt++;
        total_cnt++; if (r_pair_err != 0) $display("FAIL nom_pairs bad=%0d want 0", r_pair_err); else pass_cnt++;
        total_cnt++; if (!r_en_drop) $display("FAIL nom_en_drop got 0 want 1"); else pass_cnt++;
        total_cnt++; if (rx_count !== 7'd64) $display("FAIL nom_rx got %0d want 64", rx_count); else pass_cnt++;
        total_cnt++; if (err_count !== 7'd0) $display("FAIL nom_err got %0d want 0", err_count); else pass_cnt++;
        total_cnt++; if (checksum !== 32'd4160) $display("FAIL nom_checksum got %0d want 4160", checksum); else pass_cnt++;
        total_cnt++; if (r_done_pulses != 1) $display("FAIL nom_done_pulses got %0d want 1", r_done_pulses); else pass_cnt++;
        total_cnt++; if (r_wait_cycles != 65) $display("FAIL nom_done_latency got %0d want 65", r_wait_cycles); else pass_cnt++;
        total_cnt++; if (r_br_late) $display("FAIL nom_br_drop got 1 want 0"); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0 || busy !== 1'b0) $display("FAIL nom_idle timeout=%b busy=%b want 0/0", timeout, busy); else pass_cnt++;
    endtask

    task automatic test_stall();
        run_block(16'd1, 16'd1, 16'd2, 16'd0, 10, 3, -1, DEPTH, 0);
        total_cnt++; if (r_bound_hit) $display("FAIL stall_bound cycle budget expired got 1 want 0"); else pass_cnt++;
        total_cnt++; if (r_held_a !== 16'd11 || r_held_b !== 16'd2) $display("FAIL stall_hold got (%0d,%0d) want (11,2)", r_held_a, r_held_b); else pass_cnt++;
        total_cnt++; if (r_acc != 64 || r_issue_cycles != 67) $display("FAIL stall_issue acc=%0d cycles=%0d want 64/67", r_acc, r_issue_cycles); else pass_cnt++;
        total_cnt++; if (r_pair_err != 0) $display("FAIL stall_pairs bad=%0d want 0", r_pair_err); else pass_cnt++;
        total_cnt++; if (err_count !== 7'd0 || rx_count !== 7'd64) $display("FAIL stall_result err=%0d rx=%0d want 0/64", err_count, rx_count); else pass_cnt++;
        total_cnt++; if (checksum !== 32'd4160) $display("FAIL stall_checksum got %0d want 4160", checksum); else pass_cnt++;
    endtask

    task automatic test_corruption();
        run_block(16'd1, 16'd1, 16'd2, 16'd0, -1, 0, 5, DEPTH, 0);
        total_cnt++; if (r_bound_hit) $display("FAIL corr_bound cycle budget expired got 1 want 0"); else pass_cnt++;
        total_cnt++; if (err_count !== 7'd1) $display("FAIL corr_err got %0d want 1", err_count); else pass_cnt++;
        total_cnt++; if (checksum !== 32'd4161) $display("FAIL corr_checksum got %0d want 4161", checksum); else pass_cnt++;
        total_cnt++; if (rx_count !== 7'd64) $display("FAIL corr_rx got %0d want 64", rx_count); else pass_cnt++;
    endtask

    task automatic test_short_burst();
        run_block(16'd1, 16'd1, 16'd2, 16'd0, -1, 0, -1, 63, 0);
        total_cnt++; if (r_bound_hit) $display("FAIL short_bound cycle budget expired got 1 want 0"); else pass_cnt++;
        total_cnt++; if (rx_count !== 7'd63) $display("FAIL short_rx got %0d want 63", rx_count); else pass_cnt++;
        total_cnt++; if (checksum !== 32'd4032 || err_count !== 7'd0) $display("FAIL short_result sum=%0d err=%0d want 4032/0", checksum, err_count); else pass_cnt++;
        total_cnt++; if (r_done_pulses != 1 || timeout !== 1'b0) $display("FAIL short_done pulses=%0d timeout=%b want 1/0", r_done_pulses, timeout); else pass_cnt++;
        total_cnt++; if (r_wait_cycles != 65) $display("FAIL short_done_latency got %0d want 65", r_wait_cycles); else pass_cnt++;
    endtask

    task automatic test_timeout();
        run_block(16'h00ff, 16'h0101, 16'hfff0, 16'h0003, -1, 0, -1, DEPTH, 1);
        total_cnt++; if (r_bound_hit) $display("FAIL to_bound cycle budget expired got 1 want 0"); else pass_cnt++;
        total_cnt++; if (r_pair_err != 0) $display("FAIL to_pairs_wrap bad=%0d want 0", r_pair_err); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b1) $display("FAIL to_flag got %b want 1", timeout); else pass_cnt++;
        total_cnt++; if (r_wait_cycles != 256) $display("FAIL to_latency got %0d want 256", r_wait_cycles); else pass_cnt++;
        total_cnt++; if (rx_count !== 7'd0 || checksum !== 32'd0) $display("FAIL to_counts rx=%0d sum=%0d want 0/0", rx_count, checksum); else pass_cnt++;
        total_cnt++; if (r_br_seen || r_done_pulses != 1) $display("FAIL to_br br_seen=%b pulses=%0d want 0/1", r_br_seen, r_done_pulses); else pass_cnt++;
    endtask

    task automatic test_reset_mid_issue();
        @(negedge clk);
        seed_a = 16'd7; step_a = 16'd1; seed_b = 16'd3; step_b = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; RDY_mult = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++; if (EN_mult !== 1'b1 || busy !== 1'b1) $display("FAIL rst_mid_pre EN_mult=%b busy=%b want 1/1", EN_mult, busy); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({EN_mult, EN_blockRead, busy, done, timeout} !== 5'b0) $display("FAIL rst_mid_ctrl got %b want 00000", {EN_mult, EN_blockRead, busy, done, timeout}); else pass_cnt++;
        total_cnt++; if ({rx_count, err_count, checksum, mult_input0} !== '0) $display("FAIL rst_mid_data rx=%0d err=%0d sum=%0d in0=%0d want 0", rx_count, err_count, checksum, mult_input0); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || EN_mult !== 1'b0) $display("FAIL rst_mid_idle busy=%b EN_mult=%b want 0/0", busy, EN_mult); else pass_cnt++;
        RDY_mult = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_nominal();
        test_stall();
        test_corruption();
        test_short_burst();
        test_timeout();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
